i2s_receiver: RTL and testbench
===============================

// Module: i2s_receiver
// PURPOSE
//  Synthesizable I2S slave receiver. Samples external BCK/LRCK/DATA with the system clock,
//  recovers MSB-first words (LRCK=0 left/chan 0, LRCK=1 right/chan 1, one-BCK delayed I2S format),
//  presents each word on a valid/ready stream. Sits between the I2S input pins and the sample FIFO.
//  Word length is measured from LRCK edges, so no bit-count configuration is needed.
// PARAMETERS
//  DATA_W       32   output word width; received bits beyond DATA_W are discarded
//  SYNC_STAGES  2    flip-flop synchronizer depth on bck/lrck/data (>=2)
//  TIMEOUT      256  clk cycles without a BCK rising edge before lock is dropped
// PORTS
//  clk      in   1       system clock; frequency must be >= 4x BCK
//  rst      in   1       synchronous, active-high reset
//  bck      in   1       I2S bit clock (asynchronous to clk)
//  lrck     in   1       I2S word select (asynchronous)
//  data     in   1       I2S serial data (asynchronous); changes on BCK fall
//  m_data   out  DATA_W  received word, MSB-aligned, unused LSBs zero
//  m_chan   out  1       channel of m_data (0 left, 1 right)
//  m_bits   out  6       bits received in the word, saturating at 63
//  m_valid  out  1       m_data/m_chan/m_bits valid
//  m_ready  in   1       consumer accepts when m_valid && m_ready
//  locked   out  1       receiver aligned to LRCK
//  overflow out  1       sticky: a completed word was dropped
//  ovf_clr  in   1       clears overflow
// BEHAVIOUR
//  - Reset: all outputs 0; sync chains, shift reg, bit count and timeout counter cleared; locked=0.
//  - bck, lrck and data each pass through SYNC_STAGES flops. bck_rise is (bck_s && !bck_s_d).
//    lrck_s and data_s are taken from the same stage as bck_s.
//  - On each bck_rise, lrck_s is compared with lrck_prev, then lrck_prev <= lrck_s.
//  - Not locked: bits are ignored. On the first bck_rise with lrck_s != lrck_prev:
//    locked<=1, sreg<=0, cnt<=0. No word is emitted for this edge (partial word discarded).
//  - Locked, bck_rise, no LRCK change:
//    - if cnt<DATA_W: sreg[DATA_W-1-cnt] <= data_s
//    - cnt <= cnt+1, saturating at 63
//  - Locked, bck_rise, LRCK change (this bit is the LSB of the old word):
//    - word = sreg with data_s placed as above, bits = sat(cnt+1), chan = lrck_prev
//    - the word is emitted, then sreg<=0, cnt<=0
//  - Emission timing: m_valid is high in the cycle after the cycle in which bck_rise is detected.
//    Pin-to-m_valid latency is SYNC_STAGES+2 clk.
//  - Handshake:
//    - m_valid and the payload hold until m_valid && m_ready.
//    - Emit while m_valid && !m_ready: new word dropped, pending word kept, overflow<=1.
//    - Emit while m_valid && m_ready: new word loaded, m_valid stays 1, no overflow.
//  - overflow: set has priority over ovf_clr in the same cycle.
//  - Timeout: counter resets on every bck_rise and increments otherwise.
//    - On reaching TIMEOUT: locked<=0, sreg/cnt cleared.
//    - A pending output word is kept.
//    - Relock follows the rule above.
//  - rst mid-word: the partial word is lost. The next complete word after relock is emitted normally.
// TESTING
//  1. 16-bit stereo, words L=16'hA5C3, R=16'h1234, after one lock frame ->
//     m_data=32'hA5C3_0000 chan0 bits16, then 32'h1234_0000 chan1 bits16; m_ready=1, no overflow.
//  2. 24-bit data in 32-bit slots, L=32'hABCDEF00 -> m_data=32'hABCDEF00, m_bits=32.
//  3. DATA_W=16, 24-bit words 24'h89ABCD -> m_data=16'h89AB, m_bits=24.
//  4. m_ready=0 over three words -> first word held, overflow=1.
//     Then m_ready=1 -> first word delivered; ovf_clr clears overflow.
//  5. Stop BCK for TIMEOUT+10 clk -> locked=0.
//     Restart -> first word discarded, second word delivered correctly.
//  6. Assert rst for 1 clk mid-word -> all outputs 0; relock on next LRCK edge;
//     the subsequent word is delivered bit-exact.

Source files
------------

// File: rtl/i2s_receiver_if.sv
// ----------------------------------------------------------------------------
// i2s_receiver_if
//   Output word stream of the I2S receiver.
//
//   Handshake: the master raises m_valid with a stable payload (m_data,
//   m_chan, m_bits) and holds both until a clock edge where m_valid && m_ready
//   are both high; that edge is the single transfer point. The slave may drive
//   m_ready at any time, independent of m_valid.
//
//   Signals
//     m_data   DATA_W  received word, MSB-aligned, unused LSBs zero
//     m_chan   1       channel of the word (0 left, 1 right)
//     m_bits   6       number of bits received for the word, saturating at 63
//     m_valid  1       payload valid
//     m_ready  1       consumer accepts the payload
// ----------------------------------------------------------------------------
interface i2s_receiver_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] m_data;
  logic              m_chan;
  logic [5:0]        m_bits;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data,
    output m_chan,
    output m_bits,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_chan,
    input  m_bits,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/i2s_receiver.sv
// ----------------------------------------------------------------------------
// i2s_receiver
//   I2S slave receiver. The BCK/LRCK/DATA pins are oversampled by clk
//   (clk must run at least 4x BCK), words are recovered MSB-first in the
//   standard one-BCK-delayed I2S format and presented on a valid/ready stream.
//   Word length is taken from the spacing of LRCK edges, so any slot width
//   works; bits beyond DATA_W are dropped, m_bits still reports the full count.
//
//   Ports
//     clk, rst   system clock, synchronous active-high reset
//     bck        I2S bit clock (asynchronous)
//     lrck       I2S word select, 0 = left/chan 0, 1 = right/chan 1 (async)
//     data       I2S serial data, changes on BCK fall (async)
//     m          output word stream (i2s_receiver_if master modport)
//     locked     receiver is aligned to LRCK
//     overflow   sticky, a completed word was dropped because the stream
//                was stalled
//     ovf_clr    clears overflow (a simultaneous new overflow wins)
//     dbg_state  current alignment FSM state (0 unlocked, 1 locked)
// ----------------------------------------------------------------------------
module i2s_receiver #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bck,
  input  logic           lrck,
  input  logic           data,
  i2s_receiver_if.master m,
  output logic           locked,
  output logic           overflow,
  input  logic           ovf_clr,
  output logic           dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  // Single set bit at the MSB; shifted right by the bit count to place the
  // incoming bit. Shifts of DATA_W or more give zero, which naturally
  // discards bits past the output width.
  localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers. All three pins use the same depth so that lrck_s and
  // data_s line up with the bck_s sample that produces bck_rise.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   bck_s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      bck_sync  <= '0;
      lrck_sync <= '0;
      data_sync <= '0;
      bck_s_d   <= 1'b0;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], bck};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
      data_sync <= {data_sync[SYNC_STAGES-2:0], data};
      bck_s_d   <= bck_sync[SYNC_STAGES-1];
    end
  end

  logic bck_s;
  logic lrck_s;
  logic data_s;
  logic bck_rise;

  assign bck_s    = bck_sync[SYNC_STAGES-1];
  assign lrck_s   = lrck_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign bck_rise = bck_s & ~bck_s_d;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  state_t            state_q, state_n;
  logic              lrck_prev_q, lrck_prev_n;
  logic [DATA_W-1:0] sreg_q, sreg_n;
  logic [5:0]        cnt_q, cnt_n;
  logic [TW-1:0]     tmo_q, tmo_n;

  logic [DATA_W-1:0] out_data_q, out_data_n;
  logic              out_chan_q, out_chan_n;
  logic [5:0]        out_bits_q, out_bits_n;
  logic              out_valid_q, out_valid_n;
  logic              ovf_q, ovf_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      lrck_prev_q <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      out_data_q  <= '0;
      out_chan_q  <= 1'b0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      lrck_prev_q <= lrck_prev_n;
      sreg_q      <= sreg_n;
      cnt_q       <= cnt_n;
      tmo_q       <= tmo_n;
      out_data_q  <= out_data_n;
      out_chan_q  <= out_chan_n;
      out_bits_q  <= out_bits_n;
      out_valid_q <= out_valid_n;
      ovf_q       <= ovf_n;
    end
  end

  // --------------------------------------------------------------------------
  // Bit assembly helpers
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] sreg_ins;  // shift register with the current bit placed
  logic [5:0]        cnt_inc;   // saturating bit count including current bit
  logic              lrck_chg;
  logic              tmo_hit;

  always_comb begin
    sreg_ins = sreg_q;
    if (data_s) begin
      sreg_ins = sreg_q | (MSB_ONE >> cnt_q);
    end
  end

  assign cnt_inc  = (cnt_q == 6'd63) ? 6'd63 : cnt_q + 6'd1;
  assign lrck_chg = (lrck_s != lrck_prev_q);
  // The counter restarts on every BCK rise; the drop happens on the cycle it
  // would step onto TIMEOUT.
  assign tmo_hit  = !bck_rise && (tmo_q == TMO_LAST);

  // --------------------------------------------------------------------------
  // Alignment FSM and word assembly
  // --------------------------------------------------------------------------
  logic emit;

  always_comb begin
    state_n     = state_q;
    sreg_n      = sreg_q;
    cnt_n       = cnt_q;
    emit        = 1'b0;
    lrck_prev_n = lrck_prev_q;
    tmo_n       = tmo_q;

    if (bck_rise) begin
      lrck_prev_n = lrck_s;
      tmo_n       = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_n = tmo_q + 1'b1;
    end

    case (state_q)
      ST_UNLOCKED: begin
        // Bits seen before the first LRCK edge belong to a word whose start
        // was missed, so they are never assembled.
        if (bck_rise && lrck_chg) begin
          state_n = ST_LOCKED;
          sreg_n  = '0;
          cnt_n   = '0;
        end
      end
      ST_LOCKED: begin
        if (tmo_hit) begin
          state_n = ST_UNLOCKED;
          sreg_n  = '0;
          cnt_n   = '0;
        end else if (bck_rise) begin
          if (lrck_chg) begin
            // One-BCK delay: the bit under the LRCK edge is the LSB of the
            // word that just ended.
            emit   = 1'b1;
            sreg_n = '0;
            cnt_n  = '0;
          end else begin
            sreg_n = sreg_ins;
            cnt_n  = cnt_inc;
          end
        end
      end
      default: begin
        state_n = ST_UNLOCKED;
        sreg_n  = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output stage: one-word holding register with drop-on-stall
  // --------------------------------------------------------------------------
  always_comb begin
    out_data_n  = out_data_q;
    out_chan_n  = out_chan_q;
    out_bits_n  = out_bits_q;
    out_valid_n = out_valid_q;
    ovf_n       = ovf_q;

    if (ovf_clr) begin
      ovf_n = 1'b0;
    end

    if (out_valid_q && m.m_ready) begin
      out_valid_n = 1'b0;
    end

    if (emit) begin
      if (out_valid_q && !m.m_ready) begin
        // The consumer still owns the pending word: keep it, drop the new
        // one. Setting here overrides a same-cycle ovf_clr.
        ovf_n = 1'b1;
      end else begin
        out_data_n  = sreg_ins;
        out_chan_n  = lrck_prev_q;
        out_bits_n  = cnt_inc;
        out_valid_n = 1'b1;
      end
    end
  end

  assign m.m_data  = out_data_q;
  assign m.m_chan  = out_chan_q;
  assign m.m_bits  = out_bits_q;
  assign m.m_valid = out_valid_q;
  assign overflow  = ovf_q;
  assign locked    = (state_q == ST_LOCKED);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// ----------------------------------------------------------------------------
// tb_i2s_receiver
//   Drives an I2S bit stream into two receivers sharing the same pins: one
//   with a 32-bit output word and one with a 16-bit output word (truncation).
//   The stream is described as a list of slots (value, width, channel); the
//   expected words follow directly from the slot list: every slot except the
//   first and the last of a burst is delivered, MSB-aligned, with its width
//   saturated at 63.
// ----------------------------------------------------------------------------
module tb_i2s_receiver;

  localparam int TMO = 256;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst     = 1'b1;
  logic bck     = 1'b0;
  logic lrck    = 1'b0;
  logic data    = 1'b0;
  logic m_ready = 1'b0;
  logic ovf_clr = 1'b0;

  logic locked32, ovf32, dbg32;
  logic locked16, ovf16, dbg16;

  i2s_receiver_if #(.DATA_W(32)) s32 ();
  i2s_receiver_if #(.DATA_W(16)) s16 ();

  assign s32.m_ready = m_ready;
  assign s16.m_ready = m_ready;

  i2s_receiver #(.DATA_W(32), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .bck       (bck),
    .lrck      (lrck),
    .data      (data),
    .m         (s32),
    .locked    (locked32),
    .overflow  (ovf32),
    .ovf_clr   (ovf_clr),
    .dbg_state (dbg32)
  );

  i2s_receiver #(.DATA_W(16), .SYNC_STAGES(3), .TIMEOUT(TMO)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .bck       (bck),
    .lrck      (lrck),
    .data      (data),
    .m         (s16),
    .locked    (locked16),
    .overflow  (ovf16),
    .ovf_clr   (ovf_clr),
    .dbg_state (dbg16)
  );

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  logic [38:0] exp_q32[$];  // {chan, bits[5:0], data[31:0]}
  logic [22:0] exp_q16[$];  // {chan, bits[5:0], data[15:0]}

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] slot_val[16];  // left-aligned word value
  int           slot_w[16];
  logic         slot_ch[16];
  int           n_slots   = 0;
  logic         last_lrck = 1'b0;

  int ready_mode = 2;  // 0 random (high at least every 8th cycle), 1 low, 2 high
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // --------------------------------------------------------------------------
  // Consumer ready driver
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       m_ready = (cyc % 8 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        1:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: pops the expected queue on every accepted word
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (s32.m_valid && m_ready) begin
      if (exp_q32.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL m32_unexpected_word actual=%0h required=none at %0t", s32.m_data, $time);
      end else begin
        logic [38:0] e;
        e = exp_q32.pop_front();
        check("m32_data", 64'(s32.m_data), 64'(e[31:0]));
        check("m32_bits", 64'(s32.m_bits), 64'(e[37:32]));
        check("m32_chan", 64'(s32.m_chan), 64'(e[38]));
      end
    end
    if (s16.m_valid && m_ready) begin
      if (exp_q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL m16_unexpected_word actual=%0h required=none at %0t", s16.m_data, $time);
      end else begin
        logic [22:0] e;
        e = exp_q16.pop_front();
        check("m16_data", 64'(s16.m_data), 64'(e[15:0]));
        check("m16_bits", 64'(s16.m_bits), 64'(e[21:16]));
        check("m16_chan", 64'(s16.m_chan), 64'(e[22]));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  // v holds the word right-aligned in its low w bits.
  task automatic add_slot(input logic [127:0] v, input int w);
    slot_val[n_slots] = v << (128 - w);
    slot_w[n_slots]   = w;
    n_slots++;
  endtask

  // One BCK period: lrck/data change with the falling edge.
  task automatic drive_bit(input logic lr, input logic d, input int half);
    bck  = 1'b0;
    lrck = lr;
    data = d;
    repeat (half) @(posedge clk);
    #2;
    bck = 1'b1;
    repeat (half) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_m32_valid", 64'(s32.m_valid), 64'd0);
    check("rst_m32_data",  64'(s32.m_data),  64'd0);
    check("rst_m32_bits",  64'(s32.m_bits),  64'd0);
    check("rst_m32_chan",  64'(s32.m_chan),  64'd0);
    check("rst_locked32",  64'(locked32),    64'd0);
    check("rst_ovf32",     64'(ovf32),       64'd0);
    check("rst_m16_valid", 64'(s16.m_valid), 64'd0);
    check("rst_locked16",  64'(locked16),    64'd0);
    rst = 1'b0;
  endtask

  // Sends the slot list as one continuous burst. Channels alternate starting
  // from the current LRCK level, so the first slot is never aligned and the
  // last slot is never terminated: neither is expected. With rst_slot >= 0 a
  // one-cycle reset lands mid-way through that (left) slot, losing it; the
  // receiver relocks at the next slot. With hold set, the consumer is stalled
  // and only the first completed word survives.
  task automatic run_burst(input int half, input int rst_slot, input bit hold);
    bit pushed;
    pushed = 1'b0;
    for (int j = 0; j < n_slots; j++) slot_ch[j] = last_lrck ^ j[0];
    for (int j = 1; j < n_slots - 1; j++) begin
      if (j != rst_slot && !(hold && pushed)) begin
        logic [5:0] b;
        b = (slot_w[j] > 63) ? 6'd63 : 6'(slot_w[j]);
        exp_q32.push_back({slot_ch[j], b, slot_val[j][127:96]});
        exp_q16.push_back({slot_ch[j], b, slot_val[j][127:112]});
        pushed = 1'b1;
      end
    end
    for (int j = 0; j < n_slots; j++) begin
      for (int k = 0; k < slot_w[j]; k++) begin
        logic d;
        if (k == 0) d = (j == 0) ? 1'b0 : slot_val[j-1][128 - slot_w[j-1]];
        else        d = slot_val[j][128 - k];
        if (j == rst_slot && k == slot_w[j] / 2) do_reset();
        drive_bit(slot_ch[j], d, half);
      end
    end
    last_lrck = slot_ch[n_slots-1];
    @(negedge clk);
    check("burst_locked32", 64'(locked32), 64'd1);
    check("burst_locked16", 64'(locked16), 64'd1);
    check("burst_dbg32",    64'(dbg32),    64'd1);
  endtask

  // BCK stops for longer than the timeout; lock must drop.
  task automatic gap_check(input bit exp_ovf, input int q_left);
    repeat (TMO + 10) @(posedge clk);
    @(negedge clk);
    check("gap_locked32", 64'(locked32), 64'd0);
    check("gap_locked16", 64'(locked16), 64'd0);
    check("gap_dbg16",    64'(dbg16),    64'd0);
    check("gap_ovf32",    64'(ovf32),    64'(exp_ovf));
    check("gap_ovf16",    64'(ovf16),    64'(exp_ovf));
    check("gap_q32_left", 64'(exp_q32.size()), 64'(q_left));
    check("gap_q16_left", 64'(exp_q16.size()), 64'(q_left));
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int r;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("init_m32_valid", 64'(s32.m_valid), 64'd0);
    check("init_m32_data",  64'(s32.m_data),  64'd0);
    check("init_locked32",  64'(locked32),    64'd0);
    check("init_ovf32",     64'(ovf32),       64'd0);
    check("init_m16_valid", 64'(s16.m_valid), 64'd0);
    check("init_ovf16",     64'(ovf16),       64'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // 16-bit stereo with known words after a lock frame
    ready_mode = 2;
    n_slots = 0;
    add_slot(rnd(), 16);
    add_slot(rnd(), 16);
    add_slot(128'hA5C3, 16);
    add_slot(128'h1234, 16);
    add_slot(rnd(), 16);
    run_burst(3, -1, 1'b0);
    gap_check(1'b0, 0);

    // 32-bit slots carrying a 24-bit sample
    ready_mode = 0;
    n_slots = 0;
    add_slot(rnd(), 32);
    add_slot(128'hABCDEF00, 32);
    add_slot(rnd(), 32);
    add_slot(rnd(), 32);
    add_slot(rnd(), 32);
    run_burst(2, -1, 1'b0);
    gap_check(1'b0, 0);

    // 24-bit words: the 16-bit receiver keeps only the top 16 bits
    n_slots = 0;
    add_slot(rnd(), 24);
    add_slot(128'h89ABCD, 24);
    add_slot(rnd(), 24);
    add_slot(rnd(), 24);
    run_burst(3, -1, 1'b0);
    gap_check(1'b0, 0);

    // Stalled consumer over three words
    ready_mode = 1;
    n_slots = 0;
    for (int i = 0; i < 5; i++) add_slot(rnd(), 16);
    run_burst(2, -1, 1'b1);
    gap_check(1'b1, 1);
    check("hold_m32_valid", 64'(s32.m_valid), 64'd1);
    ready_mode = 2;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("hold_q32_drained", 64'(exp_q32.size()), 64'd0);
    check("hold_q16_drained", 64'(exp_q16.size()), 64'd0);
    check("hold_ovf32_sticky", 64'(ovf32), 64'd1);
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    check("clr_ovf32", 64'(ovf32), 64'd0);
    check("clr_ovf16", 64'(ovf16), 64'd0);

    // Long words: bit count saturates at 63
    ready_mode = 0;
    n_slots = 0;
    add_slot(rnd(), 20);
    add_slot(rnd(), 70);
    add_slot(rnd(), 64);
    add_slot(rnd(), 63);
    add_slot(rnd(), 12);
    add_slot(rnd(), 9);
    run_burst(2, -1, 1'b0);
    gap_check(1'b0, 0);

    // Reset in the middle of a left word
    ready_mode = 2;
    n_slots = 0;
    for (int i = 0; i < 6; i++) add_slot(rnd(), 32);
    r = (last_lrck == 1'b0) ? 2 : 3;
    run_burst(3, r, 1'b0);
    gap_check(1'b0, 0);

    // Random bursts with mixed widths and a jittery consumer
    for (int b = 0; b < 3; b++) begin
      int ns;
      ready_mode = 0;
      n_slots = 0;
      ns = $urandom_range(3, 7);
      for (int i = 0; i < ns; i++) add_slot(rnd(), $urandom_range(4, 40));
      run_burst($urandom_range(2, 3), -1, 1'b0);
      gap_check(1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
